// File: rtl/dsp_simd2x_int9xuint8_stim.sv
// rtl/dsp_simd2x_int9xuint8_stim.sv - stimulus generator for the 2x int9 x uint8 SIMD multiplier
// Emits a full sweep or an LFSR-random vector stream and a latency-matched scoreboard enable.
module dsp_simd2x_int9xuint8_stim #(
  parameter int unsigned DUV_LATENCY = 4,
  parameter logic [31:0] LFSR_SEED   = 32'hACE12468,
  parameter int unsigned NUM_RANDOM  = 1024
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        start,
  input  logic        mode,
  input  logic        stall,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [8:0]  coeff,
  output logic        valid,
  output logic        scoreboard_en,
  output logic        scoreboard_reset,
  output logic        busy,
  output logic        done,
  output logic [31:0] vec_count
);

  localparam logic [31:0] LFSR_MASK   = 32'h80200003;
  localparam logic [31:0] SEED_EFF    = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
  localparam logic [31:0] SWEEP_TOTAL = 32'd131072;
  localparam logic [31:0] RAND_TOTAL  = 32'(NUM_RANDOM);
  localparam logic [4:0]  DRAIN_LAST  = 5'(DUV_LATENCY - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                 state, state_n;
  logic                   mode_q;
  logic [31:0]            lfsr, lfsr_n;
  logic [4:0]             drain_cnt;
  logic [DUV_LATENCY-1:0] lat_sr;
  logic [31:0]            total;
  logic                   accept, last_issue;

  assign accept        = start && (state == S_IDLE || state == S_DONE);
  assign total         = mode_q ? RAND_TOTAL : SWEEP_TOTAL;
  assign valid         = (state == S_RUN) && !stall;
  assign last_issue    = valid && (vec_count == total - 32'd1);
  assign scoreboard_en = lat_sr[DUV_LATENCY-1];

  // Galois step: shift right, fold the mask back in when a one falls out
  always_comb begin
    lfsr_n = {1'b0, lfsr[31:1]};
    if (lfsr[0]) lfsr_n = lfsr_n ^ LFSR_MASK;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n          = state;
    scoreboard_reset = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    unique case (state)
      S_IDLE:  if (accept) state_n = S_CLEAR;
      S_CLEAR: begin
        scoreboard_reset = 1'b1;
        busy             = 1'b1;
        state_n          = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_issue) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DRAIN_LAST) state_n = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (accept) state_n = S_CLEAR;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      mode_q    <= 1'b0;
      lfsr      <= SEED_EFF;
      a         <= 8'd0;
      b         <= 8'd0;
      coeff     <= 9'd0;
      vec_count <= 32'd0;
      drain_cnt <= 5'd0;
      lat_sr    <= '0;
    end else begin
      lat_sr <= (lat_sr << 1) | DUV_LATENCY'(valid);

      if (accept) begin
        mode_q    <= mode;
        vec_count <= 32'd0;
      end

      if (state == S_CLEAR) begin
        lfsr      <= SEED_EFF;
        drain_cnt <= 5'd0;
        if (mode_q) begin
          a     <= SEED_EFF[7:0];
          b     <= SEED_EFF[15:8];
          coeff <= SEED_EFF[24:16];
        end else begin
          a     <= 8'd0;
          b     <= 8'hFF;
          coeff <= 9'h100;
        end
      end

      if (state == S_DRAIN) drain_cnt <= drain_cnt + 5'd1;

      if (valid) begin
        if (vec_count != 32'hFFFF_FFFF) vec_count <= vec_count + 32'd1;
        // the final vector stays on the outputs through DRAIN and DONE
        if (!last_issue) begin
          if (mode_q) begin
            lfsr  <= lfsr_n;
            a     <= lfsr_n[7:0];
            b     <= lfsr_n[15:8];
            coeff <= lfsr_n[24:16];
          end else begin
            if (a == 8'hFF) coeff <= coeff + 9'd1;
            a <= a + 8'd1;
            b <= b - 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dsp_simd2x_int9xuint8_stim.sv
// tb/tb_dsp_simd2x_int9xuint8_stim.sv - self-checking bench for dsp_simd2x_int9xuint8_stim
module tb_dsp_simd2x_int9xuint8_stim;

  localparam int          L    = 4;
  localparam int          NR   = 8;
  localparam logic [31:0] SEED = 32'h1;
  localparam logic [31:0] MASK = 32'h80200003;

  logic        clk    = 1'b0;
  logic        areset = 1'b1;
  logic        start  = 1'b0;
  logic        mode   = 1'b0;
  logic        stall  = 1'b0;
  logic [7:0]  a, b;
  logic [8:0]  coeff;
  logic        valid, scoreboard_en, scoreboard_reset, busy, done;
  logic [31:0] vec_count;

  dsp_simd2x_int9xuint8_stim #(
    .DUV_LATENCY(L), .LFSR_SEED(SEED), .NUM_RANDOM(NR)
  ) dut (
    .clk(clk), .areset(areset), .start(start), .mode(mode), .stall(stall),
    .a(a), .b(b), .coeff(coeff), .valid(valid), .scoreboard_en(scoreboard_en),
    .scoreboard_reset(scoreboard_reset), .busy(busy), .done(done), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [24:0] issued[$];
  logic        vhist[$];
  int          sb_count = 0;
  logic [24:0] exp_rand[NR];

  typedef struct {
    int               idx;
    logic [7:0]       ea;
    logic [7:0]       eb;
    logic signed [8:0] ec;
  } sweep_vec_t;
  sweep_vec_t sweep_tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    logic [31:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ MASK;
    return y;
  endfunction

  function automatic logic [24:0] vec_of(input logic [31:0] x);
    return {x[7:0], x[15:8], x[24:16]};
  endfunction

  function automatic logic [63:0] outs();
    return {2'b00, a, b, coeff, valid, scoreboard_en, scoreboard_reset, busy, done, vec_count};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start is sampled on the next edge; returns one step into the CLEAR cycle
  task automatic pulse_start(input logic m);
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
    mode  = ~m;
  endtask

  // scoreboard_en must reproduce valid L cycles later; history restarts at reset
  always @(negedge clk) begin : mon
    logic e;
    if (areset) begin
      vhist.delete();
    end else begin
      if (valid) issued.push_back({a, b, coeff});
      if (scoreboard_en) sb_count++;
      vhist.push_back(valid);
      e = 1'b0;
      if (vhist.size() > L) e = vhist.pop_front();
      check("sb_en_delay", {63'd0, scoreboard_en}, {63'd0, e});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          sb0;
    logic [7:0]  pat;
    logic [31:0] x;

    sweep_tbl[0] = '{0,   8'd0,   8'd255, -9'sd256};
    sweep_tbl[1] = '{1,   8'd1,   8'd254, -9'sd256};
    sweep_tbl[2] = '{2,   8'd2,   8'd253, -9'sd256};
    sweep_tbl[3] = '{255, 8'd255, 8'd0,   -9'sd256};
    sweep_tbl[4] = '{256, 8'd0,   8'd255, -9'sd255};
    sweep_tbl[5] = '{300, 8'd44,  8'd211, -9'sd255};
    sweep_tbl[6] = '{511, 8'd255, 8'd0,   -9'sd255};
    sweep_tbl[7] = '{512, 8'd0,   8'd255, -9'sd254};

    x = SEED;
    for (int k = 0; k < NR; k++) begin
      exp_rand[k] = vec_of(x);
      x = lfsr_step(x);
    end

    // reset and idle
    repeat (3) tick();
    check("reset_outputs", outs(), 64'd0);
    areset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_outputs", outs(), 64'd0);
    end

    // sweep: clear pulse, first vector, table of positions through two coeff steps
    issued.delete();
    pulse_start(1'b0);
    check("clear_sb_reset", {63'd0, scoreboard_reset}, 64'd1);
    check("clear_busy", {63'd0, busy}, 64'd1);
    check("clear_vec_count", {32'd0, vec_count}, 64'd0);
    tick();
    check("sweep_first_valid", {63'd0, valid}, 64'd1);
    check("sweep_first_vec", {39'd0, a, b, coeff}, {39'd0, 8'd0, 8'd255, 9'h100});
    check("sb_reset_one_cycle", {63'd0, scoreboard_reset}, 64'd0);
    repeat (599) tick();
    check("sweep_vec_count", {32'd0, vec_count}, 64'd599);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("sweep_vec_%0d", sweep_tbl[i].idx), {39'd0, issued[sweep_tbl[i].idx]},
            {39'd0, sweep_tbl[i].ea, sweep_tbl[i].eb, sweep_tbl[i].ec});
    end

    // start during RUN is ignored, mode is not relatched
    pulse_start(1'b1);
    check("run_start_busy", {63'd0, busy}, 64'd1);
    check("run_start_no_clear", {63'd0, scoreboard_reset}, 64'd0);
    check("run_start_count", {32'd0, vec_count}, 64'd600);
    check("run_start_vec", {39'd0, a, b, coeff}, {39'd0, 8'd88, 8'd167, 9'h102});

    // abort mid-run
    areset = 1'b1;
    #1;
    check("abort_outputs", outs(), 64'd0);
    tick();
    tick();
    areset = 1'b0;
    sb0 = sb_count;
    repeat (L + 4) tick();
    check("abort_no_sb_en", sb_count, sb0);
    check("abort_idle", outs(), 64'd0);

    // restart runs from the first vector
    pulse_start(1'b0);
    tick();
    check("restart_count", {32'd0, vec_count}, 64'd0);
    check("restart_first_vec", {38'd0, valid, a, b, coeff}, {38'd0, 1'b1, 8'd0, 8'd255, 9'h100});
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
    tick();

    // random run, no stall: sequence, latency to done, held vector
    issued.delete();
    sb0 = sb_count;
    pulse_start(1'b1);
    cyc = 0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    check("rand_done_latency", cyc, NR + L + 1);
    check("rand_issued_n", issued.size(), NR);
    check("rand_first_const", {39'd0, issued[0]}, {39'd0, 8'd1, 8'd0, 9'd0});
    for (int k = 0; k < NR; k++)
      check($sformatf("rand_vec_%0d", k), {39'd0, issued[k]}, {39'd0, exp_rand[k]});
    check("rand_vec_count", {32'd0, vec_count}, 64'd8);
    check("rand_sb_count", sb_count - sb0, NR);
    check("rand_done_busy", {62'd0, done, busy}, 64'd2);
    check("rand_hold_last", {39'd0, a, b, coeff}, {39'd0, exp_rand[NR-1]});

    // three-cycle stall after the second vector, restarted from DONE
    issued.delete();
    sb0 = sb_count;
    pulse_start(1'b1);
    tick();
    tick();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_valid", {63'd0, valid}, 64'd0);
      check("stall_hold", {39'd0, a, b, coeff}, {39'd0, exp_rand[2]});
      check("stall_count", {32'd0, vec_count}, 64'd2);
      tick();
    end
    stall = 1'b0;
    pat = 8'd0;
    for (int i = 0; i < 8; i++) begin
      pat = {pat[6:0], scoreboard_en};
      tick();
    end
    check("stall_sb_gap", {56'd0, pat}, {56'd0, 8'b1000_1111});
    cyc = 0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    check("stall_done", {63'd0, done}, 64'd1);
    check("stall_vec_count", {32'd0, vec_count}, 64'd8);
    check("stall_sb_count", sb_count - sb0, NR);
    for (int k = 0; k < NR; k++)
      check($sformatf("stall_vec_%0d", k), {39'd0, issued[k]}, {39'd0, exp_rand[k]});

    // random stall patterns
    for (int r = 0; r < 4; r++) begin
      issued.delete();
      sb0 = sb_count;
      pulse_start(1'b1);
      cyc = 0;
      while (!done && cyc < 500) begin
        stall = ($urandom_range(0, 2) == 0);
        tick();
        cyc++;
      end
      stall = 1'b0;
      check("rstall_done", {63'd0, done}, 64'd1);
      check("rstall_vec_count", {32'd0, vec_count}, 64'd8);
      check("rstall_sb_count", sb_count - sb0, NR);
      check("rstall_issued_n", issued.size(), NR);
      for (int k = 0; k < NR; k++)
        check($sformatf("rstall_vec_%0d", k), {39'd0, issued[k]}, {39'd0, exp_rand[k]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
